// File: rtl/serial_pkg.sv
// Shared constants, state type and sizing helper for the serial digit link.
package serial_pkg;

    localparam int unsigned SERIAL_WIDTH_DEFAULT = 32;

    typedef enum logic {
        StIdle,
        StShift
    } shift_state_e;

    // Counter must hold WIDTH itself, not just WIDTH-1.
    function automatic int unsigned bitcnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_shifter.sv
// Parallel-load, MSB-first serial shifter with an active-high frame enable.
module serial_shifter
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = SERIAL_WIDTH_DEFAULT
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             load_data,
    input  logic [WIDTH-1:0] data_in,
    output logic             data_enable,
    output logic             sdo
);

    localparam int unsigned CntW = bitcnt_width(WIDTH);

    shift_state_e     r_state;
    shift_state_e     w_state_d;
    logic [WIDTH-1:0] r_shreg;
    logic [CntW-1:0]  r_bitcnt;
    logic             r_load_q;
    logic             w_accept;
    logic             w_busy;
    logic             w_last;

    assign w_accept = load_data & ~r_load_q;
    assign w_busy   = (r_state == StShift);
    assign w_last   = (r_bitcnt == CntW'(1));

    always_ff @(posedge sclk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // A fresh load always wins, so a restart or back-to-back word never drops the frame.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) w_state_d = StShift;
            end
            StShift: begin
                if (!w_accept && w_last) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_load_q <= 1'b0;
        end else begin
            r_load_q <= load_data;
            if (w_accept) begin
                r_shreg  <= data_in;
                r_bitcnt <= CntW'(WIDTH);
            end else if (w_busy) begin
                r_shreg  <= {r_shreg[WIDTH-2:0], 1'b0};
                r_bitcnt <= r_bitcnt - CntW'(1);
            end
        end
    end

    always_comb begin
        data_enable = w_busy;
        sdo         = w_busy ? r_shreg[WIDTH-1] : 1'b0;
    end

endmodule

// File: tb/tb_serial_shifter.sv
// Directed bench for serial_shifter: vector table plus multi-cycle corner sequences.
module tb_serial_shifter;

    localparam int unsigned W = 32;

    logic         sclk;
    logic         rst;
    logic         load_data;
    logic [W-1:0] data_in;
    logic         data_enable;
    logic         sdo;

    int n_vec;
    int n_err;

    serial_shifter #(.WIDTH(W)) dut (
        .sclk        (sclk),
        .rst         (rst),
        .load_data   (load_data),
        .data_in     (data_in),
        .data_enable (data_enable),
        .sdo         (sdo)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    typedef struct {
        logic         rst;
        logic         load;
        logic [W-1:0] data;
        logic         exp_de;
        logic         exp_sdo;
    } vec_t;

    vec_t tbl[7];

    // Advance one sclk cycle, then compare outputs 1 time unit after the edge.
    task automatic tick_check(input string name, input logic exp_de, input logic exp_sdo);
        @(posedge sclk);
        #1;
        n_vec++;
        if (data_enable !== exp_de || sdo !== exp_sdo) begin
            n_err++;
            $display("FAIL %s @%0t: got de=%b sdo=%b, expected de=%b sdo=%b",
                     name, $time, data_enable, sdo, exp_de, exp_sdo);
        end
    endtask

    task automatic set_in(input logic r, input logic ld, input logic [W-1:0] d);
        rst       = r;
        load_data = ld;
        data_in   = d;
    endtask

    initial begin
        logic [W-1:0] word;
        n_vec = 0;
        n_err = 0;

        tbl[0] = '{1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 32'hA0000000, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};

        set_in(1'b1, 1'b1, 32'hDEADBEEF);
        for (int i = 0; i < 7; i++) begin
            set_in(tbl[i].rst, tbl[i].load, tbl[i].data);
            tick_check($sformatf("table[%0d]", i), tbl[i].exp_de, tbl[i].exp_sdo);
        end
        for (int k = 4; k < W; k++) tick_check("reset_release_tail", 1'b1, 1'b0);
        tick_check("reset_release_end", 1'b0, 1'b0);

        // Basic transfer; data_in scrambled after accept must be ignored.
        word = 32'hF0F00F0F;
        set_in(1'b0, 1'b1, word);
        tick_check("basic_bit0", 1'b1, word[W-1]);
        set_in(1'b0, 1'b0, 32'h12345678);
        for (int k = 1; k < W; k++) tick_check($sformatf("basic_bit%0d", k), 1'b1, word[W-1-k]);
        tick_check("basic_end", 1'b0, 1'b0);
        tick_check("basic_idle", 1'b0, 1'b0);

        // Held load: exactly one transfer over 100 cycles.
        word = 32'h80000001;
        set_in(1'b0, 1'b1, word);
        for (int c = 1; c <= 100; c++) begin
            if (c <= W) tick_check($sformatf("held_c%0d", c), 1'b1, word[W-c]);
            else        tick_check($sformatf("held_c%0d", c), 1'b0, 1'b0);
        end
        set_in(1'b0, 1'b0, '0);
        tick_check("held_release", 1'b0, 1'b0);

        // Mid-transfer restart after 10 bits.
        set_in(1'b0, 1'b1, 32'hFFFFFFFF);
        tick_check("restart_a1", 1'b1, 1'b1);
        set_in(1'b0, 1'b0, 32'hFFFFFFFF);
        for (int c = 2; c <= 10; c++) tick_check($sformatf("restart_a%0d", c), 1'b1, 1'b1);
        set_in(1'b0, 1'b1, 32'h00000000);
        tick_check("restart_b1", 1'b1, 1'b0);
        set_in(1'b0, 1'b0, 32'hFFFFFFFF);
        for (int c = 2; c <= W; c++) tick_check($sformatf("restart_b%0d", c), 1'b1, 1'b0);
        tick_check("restart_end", 1'b0, 1'b0);

        // Reset mid-transfer after 5 bits, then a normal load.
        set_in(1'b0, 1'b1, 32'hFFFFFFFF);
        tick_check("rstmid_1", 1'b1, 1'b1);
        set_in(1'b0, 1'b0, 32'hFFFFFFFF);
        for (int c = 2; c <= 5; c++) tick_check($sformatf("rstmid_%0d", c), 1'b1, 1'b1);
        set_in(1'b1, 1'b0, 32'hFFFFFFFF);
        tick_check("rstmid_abort", 1'b0, 1'b0);
        set_in(1'b0, 1'b0, 32'hFFFFFFFF);
        tick_check("rstmid_idle", 1'b0, 1'b0);
        word = 32'hA5C3_3C5A;
        set_in(1'b0, 1'b1, word);
        tick_check("rstmid_new0", 1'b1, word[W-1]);
        set_in(1'b0, 1'b0, '0);
        for (int k = 1; k < W; k++) tick_check($sformatf("rstmid_new%0d", k), 1'b1, word[W-1-k]);
        tick_check("rstmid_new_end", 1'b0, 1'b0);

        // Back-to-back: new load rising on the final bit cycle of the first word.
        word = 32'h80000001;
        set_in(1'b0, 1'b1, word);
        tick_check("b2b_a0", 1'b1, word[W-1]);
        set_in(1'b0, 1'b0, '0);
        for (int k = 1; k < W; k++) tick_check($sformatf("b2b_a%0d", k), 1'b1, word[W-1-k]);
        word = 32'hC0000003;
        set_in(1'b0, 1'b1, word);
        tick_check("b2b_b0", 1'b1, word[W-1]);
        set_in(1'b0, 1'b0, 32'h55555555);
        for (int k = 1; k < W; k++) tick_check($sformatf("b2b_b%0d", k), 1'b1, word[W-1-k]);
        tick_check("b2b_end", 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
